// File: rtl/cpu_pkg.sv
// Shared definitions for the data cache controller: address/block geometry,
// the controller FSM state type and a tag-width helper.
package cpu_pkg;

  localparam int ADDR_W      = 8;
  localparam int BLOCK_W     = 32;
  localparam int OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } dcache_state_t;

  // Tag bits left over once index and byte offset are taken from the address.
  function automatic int tag_width(input int index_bits);
    return ADDR_W - OFFSET_BITS - index_bits;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signals of the data cache controller.
// slave  : the cache controller's view.
// master : the environment's view (CPU datapath plus main memory).
// With DCACHE_STATS_EN defined, the hit/miss counters are carried as well.
interface dcache_ctrl_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;
`endif

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
`ifdef DCACHE_STATS_EN
    , output HIT_COUNT, MISS_COUNT
`endif
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
`ifdef DCACHE_STATS_EN
    , input HIT_COUNT, MISS_COUNT
`endif
  );
endinterface

// File: rtl/dcache_array.sv
// Direct-mapped block storage: valid/dirty/tag/data per block, cleared
// asynchronously. One byte-write port (store hit), one block-install port
// (miss refill) and a combinational read of the indexed block.
module dcache_array
  import cpu_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_W      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [INDEX_BITS-1:0] i_index,
  input  logic [1:0]            i_offset,
  input  logic                  i_byte_we,
  input  logic [7:0]            i_byte_wdata,
  input  logic                  i_inst_we,
  input  logic [TAG_W-1:0]      i_inst_tag,
  input  logic [BLOCK_W-1:0]    i_inst_data,
  output logic                  o_valid,
  output logic                  o_dirty,
  output logic [TAG_W-1:0]      o_tag,
  output logic [BLOCK_W-1:0]    o_block,
  output logic [7:0]            o_byte
);
  localparam int NBLK = 1 << INDEX_BITS;

  logic [NBLK-1:0]    r_valid;
  logic [NBLK-1:0]    r_dirty;
  logic [TAG_W-1:0]   r_tag  [NBLK];
  logic [BLOCK_W-1:0] r_data [NBLK];

  // Storage update: refill installs a clean block, a store hit patches one byte.
  // Tags and data are cleared too so the read path shows zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < NBLK; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_inst_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
      r_tag[i_index]   <= i_inst_tag;
      r_data[i_index]  <= i_inst_data;
    end else if (i_byte_we) begin
      r_dirty[i_index] <= 1'b1;
      r_data[i_index][{i_offset, 3'b000} +: 8] <= i_byte_wdata;
    end
  end

  // Combinational lookup of the indexed block.
  always_comb begin
    o_valid = r_valid[i_index];
    o_dirty = r_dirty[i_index];
    o_tag   = r_tag[i_index];
    o_block = r_data[i_index];
    o_byte  = r_data[i_index][{i_offset, 3'b000} +: 8];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller. Serves byte loads/stores,
// stalls the CPU via BUSYWAIT while a miss is serviced (optional writeback of
// a dirty victim, then fetch and install of the requested block).
// Optional feature macro: DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT.
//
// state     | meaning
// IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or FETCH
// WRITEBACK | MEM_WRITE the victim block until memory drops MEM_BUSYWAIT
// FETCH     | MEM_READ the requested block until memory drops MEM_BUSYWAIT
// UPDATE    | install MEM_READDATA as a clean valid block, back to IDLE
module dcache_ctrl
  import cpu_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  dcache_ctrl_if.slave  bus
);
  localparam int TAG_W = tag_width(INDEX_BITS);

  dcache_state_t r_state, w_state_nxt;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_offset;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_valid;
  logic                  w_dirty;
  logic [TAG_W-1:0]      w_stored_tag;
  logic [BLOCK_W-1:0]    w_block;
  logic [7:0]            w_byte;
  logic                  w_byte_we;
  logic                  w_inst_we;
  logic                  w_busy;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic [5:0]            w_mem_addr;
  logic [BLOCK_W-1:0]    w_mem_wdata;

  assign w_tag    = bus.ADDRESS[ADDR_W-1 -: TAG_W];
  assign w_index  = bus.ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign w_offset = bus.ADDRESS[1:0];
  assign w_req    = bus.READ | bus.WRITE;
  assign w_hit    = w_valid && (w_stored_tag == w_tag);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .i_clk        (CLK),
    .i_rst_n      (RESET_N),
    .i_index      (w_index),
    .i_offset     (w_offset),
    .i_byte_we    (w_byte_we),
    .i_byte_wdata (bus.WRITEDATA),
    .i_inst_we    (w_inst_we),
    .i_inst_tag   (w_tag),
    .i_inst_data  (bus.MEM_READDATA),
    .o_valid      (w_valid),
    .o_dirty      (w_dirty),
    .o_tag        (w_stored_tag),
    .o_block      (w_block),
    .o_byte       (w_byte)
  );

  // State register; reset abandons any in-flight memory access.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, memory strobes and array write enables.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_byte_we   = 1'b0;
    w_inst_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            // WRITE wins when both strobes are high.
            w_byte_we = bus.WRITE;
          end else begin
            w_busy      = 1'b1;
            w_state_nxt = w_dirty ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        w_busy      = 1'b1;
        w_mem_write = 1'b1;
        w_mem_addr  = {w_stored_tag, w_index};
        w_mem_wdata = w_block;
        if (!bus.MEM_BUSYWAIT) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_busy     = 1'b1;
        w_mem_read = 1'b1;
        w_mem_addr = {w_tag, w_index};
        if (!bus.MEM_BUSYWAIT) w_state_nxt = UPDATE;
      end
      UPDATE: begin
        w_busy      = 1'b1;
        w_inst_we   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A missing request in IDLE would otherwise stall the CPU during reset.
  assign bus.BUSYWAIT      = RESET_N & w_busy;
  assign bus.READDATA      = w_byte;
  assign bus.MEM_READ      = w_mem_read;
  assign bus.MEM_WRITE     = w_mem_write;
  assign bus.MEM_ADDRESS   = w_mem_addr;
  assign bus.MEM_WRITEDATA = w_mem_wdata;

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        r_retry;

  // Count requests resolved in IDLE; the retried hit right after UPDATE is
  // the tail of a miss already counted, so it is skipped.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_retry    <= 1'b0;
    end else begin
      r_retry <= (r_state == UPDATE);
      if (r_state == IDLE && w_req) begin
        if (w_hit) begin
          if (!r_retry && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
        end else if (r_miss_cnt != 16'hFFFF) begin
          r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.HIT_COUNT  = r_hit_cnt;
  assign bus.MISS_COUNT = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios from the cache's
// intended behaviour, then randomized traffic checked against a
// transaction-level cache/memory model. Stats checks apply under DCACHE_STATS_EN.
module tb_dcache_ctrl;

  logic CLK = 1'b0;
  logic RESET_N;

  dcache_ctrl_if bus ();

  dcache_ctrl #(.INDEX_BITS(3)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- main memory model ----------------
  logic [31:0] mem_w [64];
  logic [31:0] mem_rdata;
  bit          mem_ready;
  int          lat;
  int          mcnt;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] h;
    if (i == 5) return 32'hDDCCBBAA;
    h = 32'(i + 1) * 32'h9E3779B9;
    return h;
  endfunction

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (mcnt != lat - 1);
  assign bus.MEM_READDATA = mem_rdata;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem_w[i] <= init_word(i);
      mem_ready <= 1'b1;
      mcnt      <= 0;
      mem_rdata <= '0;
    end else if (bus.MEM_READ | bus.MEM_WRITE) begin
      if (mcnt == lat - 1) begin
        mcnt <= 0;
        if (bus.MEM_WRITE) mem_w[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
        else               mem_rdata <= mem_w[bus.MEM_ADDRESS];
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // ---------------- reference model ----------------
  bit          mv [8];
  bit          md [8];
  logic [2:0]  mt [8];
  logic [31:0] mdat [8];
  logic [31:0] mmem [64];
  int          exp_hits, exp_misses;

  int          e_busy;
  logic [7:0]  e_rd;
  logic        e_wb, e_miss;
  logic [5:0]  e_wb_addr, e_rd_addr;
  logic [31:0] e_wb_data;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic ref_access(input logic wr, input logic [7:0] a, input logic [7:0] d, input int L);
    int idx, tg, o;
    idx = int'(a[4:2]);
    tg  = int'(a[7:5]);
    o   = int'(a[1:0]);
    e_wb = 1'b0; e_miss = 1'b0; e_wb_addr = '0; e_wb_data = '0;
    e_rd_addr = 6'(tg * 8 + idx);
    if (mv[idx] && int'(mt[idx]) == tg) begin
      e_busy = 0;
      exp_hits++;
    end else begin
      e_miss = 1'b1;
      exp_misses++;
      if (md[idx]) begin
        e_wb      = 1'b1;
        e_wb_addr = 6'(int'(mt[idx]) * 8 + idx);
        e_wb_data = mdat[idx];
        mmem[e_wb_addr] = mdat[idx];
        e_busy = 2 * L + 2;
      end else begin
        e_busy = L + 2;
      end
      mdat[idx] = mmem[e_rd_addr];
      mv[idx] = 1'b1;
      mt[idx] = 3'(tg);
      md[idx] = 1'b0;
    end
    e_rd = mdat[idx][o*8 +: 8];
    if (wr) begin
      mdat[idx][o*8 +: 8] = d;
      md[idx] = 1'b1;
    end
  endtask

  // ---------------- CPU-side driver ----------------
  int          obs_busy, obs_rdc, obs_wrc;
  logic [7:0]  obs_rd;
  logic [5:0]  obs_raddr, obs_waddr;
  logic [31:0] obs_wdata;

  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = d;
    #1;
    obs_busy = 0; obs_rdc = 0; obs_wrc = 0;
    obs_raddr = '0; obs_waddr = '0; obs_wdata = '0;
    while (bus.BUSYWAIT === 1'b1 && obs_busy < 200) begin
      obs_busy++;
      if (bus.MEM_READ)  begin obs_rdc++; obs_raddr = bus.MEM_ADDRESS; end
      if (bus.MEM_WRITE) begin obs_wrc++; obs_waddr = bus.MEM_ADDRESS; obs_wdata = bus.MEM_WRITEDATA; end
      @(negedge CLK); #1;
    end
    obs_rd = bus.READDATA;
    @(posedge CLK); #1;
    bus.READ = 1'b0; bus.WRITE = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET_N = 1'b0;
    bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = 8'h00; bus.WRITEDATA = 8'h00;
    lat = 4;
    model_reset();
    for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
    #22;
    n_checks++; if (bus.BUSYWAIT !== 1'b0) begin n_errors++; $display("FAIL reset_busywait: got %b expected 0", bus.BUSYWAIT); end
    n_checks++; if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0/0", bus.MEM_READ, bus.MEM_WRITE); end
    n_checks++; if (bus.MEM_ADDRESS !== 6'h00) begin n_errors++; $display("FAIL reset_mem_addr: got %h expected 00", bus.MEM_ADDRESS); end
    n_checks++; if (bus.MEM_WRITEDATA !== 32'h0) begin n_errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.MEM_WRITEDATA); end
    n_checks++; if (bus.READDATA !== 8'h00) begin n_errors++; $display("FAIL reset_readdata: got %h expected 00", bus.READDATA); end
`ifdef DCACHE_STATS_EN
    n_checks++; if (bus.HIT_COUNT !== 16'd0 || bus.MISS_COUNT !== 16'd0) begin n_errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", bus.HIT_COUNT, bus.MISS_COUNT); end
`endif
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_cold_read();
    lat = 4;
    ref_access(1'b0, 8'h14, 8'h00, lat);
    do_req(1'b1, 1'b0, 8'h14, 8'h00);
    n_checks++; if (obs_busy != 6) begin n_errors++; $display("FAIL cold_busy_cycles: got %0d expected 6", obs_busy); end
    n_checks++; if (obs_rdc != 4) begin n_errors++; $display("FAIL cold_mem_read_cycles: got %0d expected 4", obs_rdc); end
    n_checks++; if (obs_raddr !== 6'h05) begin n_errors++; $display("FAIL cold_mem_addr: got %h expected 05", obs_raddr); end
    n_checks++; if (obs_rd !== 8'hAA) begin n_errors++; $display("FAIL cold_readdata: got %h expected AA", obs_rd); end
  endtask

  task automatic test_read_hit();
    ref_access(1'b0, 8'h16, 8'h00, lat);
    do_req(1'b1, 1'b0, 8'h16, 8'h00);
    n_checks++; if (obs_busy != 0 || obs_rdc != 0) begin n_errors++; $display("FAIL hit_stall: got busy=%0d memrd=%0d expected 0/0", obs_busy, obs_rdc); end
    n_checks++; if (obs_rd !== 8'hCC) begin n_errors++; $display("FAIL hit_readdata: got %h expected CC", obs_rd); end
  endtask

  task automatic test_write_hit();
    ref_access(1'b1, 8'h15, 8'h5A, lat);
    do_req(1'b0, 1'b1, 8'h15, 8'h5A);
    n_checks++; if (obs_busy != 0 || obs_wrc != 0) begin n_errors++; $display("FAIL write_hit_stall: got busy=%0d memwr=%0d expected 0/0", obs_busy, obs_wrc); end
  endtask

  task automatic test_dirty_miss();
    lat = 4;
    ref_access(1'b0, 8'h34, 8'h00, lat);
    do_req(1'b1, 1'b0, 8'h34, 8'h00);
    n_checks++; if (obs_busy != 10) begin n_errors++; $display("FAIL dirty_busy_cycles: got %0d expected 10", obs_busy); end
    n_checks++; if (obs_wrc != 4) begin n_errors++; $display("FAIL dirty_mem_write_cycles: got %0d expected 4", obs_wrc); end
    n_checks++; if (obs_waddr !== 6'h05) begin n_errors++; $display("FAIL dirty_wb_addr: got %h expected 05", obs_waddr); end
    n_checks++; if (obs_wdata !== 32'hDDCC5AAA) begin n_errors++; $display("FAIL dirty_wb_data: got %h expected DDCC5AAA", obs_wdata); end
    n_checks++; if (obs_raddr !== 6'h0D || obs_rdc != 4) begin n_errors++; $display("FAIL dirty_fetch: got addr=%h cycles=%0d expected 0D/4", obs_raddr, obs_rdc); end
    n_checks++; if (obs_rd !== e_rd) begin n_errors++; $display("FAIL dirty_readdata: got %h expected %h", obs_rd, e_rd); end
  endtask

  task automatic test_read_write_priority();
    ref_access(1'b1, 8'h35, 8'h77, lat);
    do_req(1'b1, 1'b1, 8'h35, 8'h77);
    n_checks++; if (obs_busy != 0) begin n_errors++; $display("FAIL rw_stall: got %0d expected 0", obs_busy); end
`ifdef DCACHE_STATS_EN
    #1;
    n_checks++; if (bus.HIT_COUNT !== 16'd3) begin n_errors++; $display("FAIL stats_hits: got %0d expected 3", bus.HIT_COUNT); end
    n_checks++; if (bus.MISS_COUNT !== 16'd2) begin n_errors++; $display("FAIL stats_misses: got %0d expected 2", bus.MISS_COUNT); end
`endif
    ref_access(1'b0, 8'h35, 8'h00, lat);
    do_req(1'b1, 1'b0, 8'h35, 8'h00);
    n_checks++; if (obs_rd !== 8'h77 || obs_busy != 0) begin n_errors++; $display("FAIL rw_store_took: got data=%h busy=%0d expected 77/0", obs_rd, obs_busy); end
  endtask

  task automatic test_reset_mid_fetch();
    int k;
    lat = 4;
    @(negedge CLK);
    bus.READ = 1'b1; bus.WRITE = 1'b0; bus.ADDRESS = 8'h08;
    #1;
    k = 0;
    while (bus.MEM_READ !== 1'b1 && k < 20) begin @(negedge CLK); #1; k++; end
    n_checks++; if (bus.MEM_READ !== 1'b1) begin n_errors++; $display("FAIL midreset_fetch_start: got %b expected 1", bus.MEM_READ); end
    @(negedge CLK); #2;
    RESET_N = 1'b0;
    #1;
    n_checks++; if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin n_errors++; $display("FAIL midreset_strobes: got rd=%b wr=%b expected 0/0", bus.MEM_READ, bus.MEM_WRITE); end
    n_checks++; if (bus.BUSYWAIT !== 1'b0) begin n_errors++; $display("FAIL midreset_busywait: got %b expected 0", bus.BUSYWAIT); end
    n_checks++; if (bus.MEM_ADDRESS !== 6'h00 || bus.READDATA !== 8'h00) begin n_errors++; $display("FAIL midreset_outputs: got addr=%h data=%h expected 00/00", bus.MEM_ADDRESS, bus.READDATA); end
    bus.READ = 1'b0;
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    ref_access(1'b0, 8'h14, 8'h00, lat);
    do_req(1'b1, 1'b0, 8'h14, 8'h00);
    n_checks++; if (obs_busy != 6 || obs_raddr !== 6'h05) begin n_errors++; $display("FAIL postreset_miss: got busy=%0d addr=%h expected 6/05", obs_busy, obs_raddr); end
    n_checks++; if (obs_rd !== e_rd || obs_rd !== 8'hAA) begin n_errors++; $display("FAIL postreset_readdata: got %h expected AA", obs_rd); end
  endtask

  task automatic test_random();
    int op;
    logic rd, wr;
    logic [7:0] a, d;
    for (int n = 0; n < 250; n++) begin
      op  = int'($urandom_range(0, 3));
      rd  = (op != 2);
      wr  = (op >= 2);
      a   = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d   = 8'($urandom);
      lat = int'($urandom_range(2, 5));
      ref_access(wr, a, d, lat);
      do_req(rd, wr, a, d);
      n_checks++; if (obs_busy != e_busy) begin n_errors++; $display("FAIL rnd_busy[%0d] a=%h: got %0d expected %0d", n, a, obs_busy, e_busy); end
      if (!wr) begin
        n_checks++; if (obs_rd !== e_rd) begin n_errors++; $display("FAIL rnd_readdata[%0d] a=%h: got %h expected %h", n, a, obs_rd, e_rd); end
      end
      if (e_miss) begin
        n_checks++; if (obs_rdc != lat || obs_raddr !== e_rd_addr) begin n_errors++; $display("FAIL rnd_fetch[%0d]: got cycles=%0d addr=%h expected %0d/%h", n, obs_rdc, obs_raddr, lat, e_rd_addr); end
      end
      if (e_wb) begin
        n_checks++; if (obs_wrc != lat || obs_waddr !== e_wb_addr || obs_wdata !== e_wb_data) begin n_errors++; $display("FAIL rnd_writeback[%0d]: got cycles=%0d addr=%h data=%h expected %0d/%h/%h", n, obs_wrc, obs_waddr, obs_wdata, lat, e_wb_addr, e_wb_data); end
      end else begin
        n_checks++; if (obs_wrc != 0) begin n_errors++; $display("FAIL rnd_no_writeback[%0d]: got %0d write cycles expected 0", n, obs_wrc); end
      end
    end
`ifdef DCACHE_STATS_EN
    #1;
    n_checks++; if (int'(bus.HIT_COUNT) != exp_hits || int'(bus.MISS_COUNT) != exp_misses) begin n_errors++; $display("FAIL rnd_stats: got %0d/%0d expected %0d/%0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hits, exp_misses); end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_read_write_priority();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
